seq_divider: RTL and testbench

- Multi-cycle unsigned restoring divider. It is the inverse-direction companion to the team's XOR-controlled adder/subtractor datapath.
- Each iteration runs a trial subtraction through an add/sub unit and produces one quotient bit per clock.
- It is a start/done handshake peripheral, used wherever the ALU needs division without a combinational array.

---
 rtl/seq_divider_pkg.sv | 13 +
 rtl/seq_divider_addsub_n.sv | 31 +++
 rtl/seq_divider.sv | 106 ++++++++++
 tb/tb_seq_divider.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared encodings for the sequential divider and its add/sub datapath.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/seq_divider_addsub_n.sv
// Parameterized ripple adder/subtractor: b is XORed with op and op feeds the carry-in.
module addsub_n #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             v
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   c;

    assign bx = b ^ {WIDTH{op}};

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = op;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            s[i]   = a[i] ^ bx[i] ^ c[i];
            c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
    end

    assign cout = c[WIDTH];
    assign v    = c[WIDTH] ^ c[WIDTH-1];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/done handshake.
// One quotient bit is produced per clock via a trial subtraction.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH:0]   p, p_shift, trial, p_step;
    logic [WIDTH-1:0] q, q_step, dvsr;
    logic [CW-1:0]    cnt;
    logic             trial_cout;
    logic             addsub_v_unused;
    logic             accept;
    logic             last_step;

    assign p_shift = {p[WIDTH-1:0], q[WIDTH-1]};

    addsub_n #(.WIDTH(WIDTH + 1)) u_addsub (
        .a    (p_shift),
        .b    ({1'b0, dvsr}),
        .op   (OP_SUB),
        .s    (trial),
        .cout (trial_cout),
        .v    (addsub_v_unused)
    );

    // Carry-out high means the trial subtraction did not borrow.
    assign p_step    = trial_cout ? trial : p_shift;
    assign q_step    = {q[WIDTH-2:0], trial_cout};
    assign last_step = (cnt == CW'(1));

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (divisor == '0) ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_step) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // The final step's result is captured straight from the step logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p           <= '0;
            q           <= '0;
            dvsr        <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            p           <= '0;
            q           <= dividend;
            dvsr        <= divisor;
            cnt         <= CW'(WIDTH);
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == ST_RUN) begin
            p   <= p_step;
            q   <= q_step;
            cnt <= cnt - CW'(1);
            if (last_step) begin
                quotient  <= q_step;
                remainder <= p_step[WIDTH-1:0];
            end
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expectations queued at launch, checked when done rises.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    typedef struct {
        logic [W-1:0] a, b, q, r;
        logic         z;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Drives one request; returns at the falling edge after the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b));
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 50) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b q=%0d r=%0d z=%b, want all zero",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        int   lat, bc;
        exp_t e;
        launch(4'd13, 4'd3, 1'b0);
        wait_done(lat, bc);
        vectors++;
        if (lat != W || bc != W) begin
            miscompares++;
            $display("FAIL basic_latency: done after %0d, busy for %0d cycles, want %0d and %0d", lat, bc, W, W);
        end
        e = sb.pop_front();
        vectors++;
        if (done !== 1'b1 || quotient !== 4'd4 || remainder !== 4'd1 || div_by_zero !== 1'b0
            || quotient !== e.q || remainder !== e.r) begin
            miscompares++;
            $display("FAIL basic_result: done=%b q=%0d r=%0d z=%b, want done=1 q=4 r=1 z=0",
                     done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || quotient !== 4'd4 || remainder !== 4'd1) begin
            miscompares++;
            $display("FAIL basic_hold: done=%b q=%0d r=%0d, want done=0 q=4 r=1", done, quotient, remainder);
        end
    endtask

    task automatic test_extremes;
        logic [W-1:0] ta[3] = '{4'd15, 4'd5, 4'd15};
        logic [W-1:0] tb[3] = '{4'd1, 4'd7, 4'd15};
        logic [W-1:0] tq[3] = '{4'd15, 4'd0, 4'd1};
        logic [W-1:0] tr[3] = '{4'd0, 4'd5, 4'd0};
        int   lat, bc;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            launch(ta[i], tb[i], 1'b0);
            wait_done(lat, bc);
            e = sb.pop_front();
            vectors++;
            if (lat != W || quotient !== tq[i] || remainder !== tr[i] || div_by_zero !== e.z) begin
                miscompares++;
                $display("FAIL extreme_%0d_%0d: lat=%0d q=%0d r=%0d z=%b, want lat=%0d q=%0d r=%0d z=0",
                         ta[i], tb[i], lat, quotient, remainder, div_by_zero, W, tq[i], tr[i]);
            end
        end
    endtask

    task automatic test_div_zero;
        int   lat, bc;
        exp_t e;
        launch(4'd9, 4'd0, 1'b0);
        wait_done(lat, bc);
        e = sb.pop_front();
        vectors++;
        if (lat != 0 || bc != 0 || quotient !== 4'd15 || remainder !== 4'd9 || div_by_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL div_zero: lat=%0d busy_cycles=%0d q=%0d r=%0d z=%b, want 0 0 q=15 r=9 z=1",
                     lat, bc, quotient, remainder, div_by_zero);
        end
        launch(4'd8, 4'd2, 1'b0);
        vectors++;
        if (div_by_zero !== 1'b0 || quotient !== 4'd15 || remainder !== 4'd9 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL div_zero_clear: z=%b q=%0d r=%0d busy=%b, want z=0 q=15 r=9 busy=1",
                     div_by_zero, quotient, remainder, busy);
        end
        wait_done(lat, bc);
        e = sb.pop_front();
        vectors++;
        if (lat != W || quotient !== e.q || remainder !== e.r || div_by_zero !== e.z) begin
            miscompares++;
            $display("FAIL after_zero: lat=%0d q=%0d r=%0d z=%b, want lat=%0d q=%0d r=%0d z=%b",
                     lat, quotient, remainder, div_by_zero, W, e.q, e.r, e.z);
        end
    endtask

    task automatic test_start_busy;
        int   lat, bc, extra;
        exp_t e;
        launch(4'd13, 4'd3, 1'b0);
        @(negedge clk);
        dividend = 4'd14;
        divisor  = 4'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        e = sb.pop_front();
        vectors++;
        if (lat != W - 2 || quotient !== e.q || remainder !== e.r || quotient !== 4'd4 || remainder !== 4'd1) begin
            miscompares++;
            $display("FAIL start_busy: lat=%0d q=%0d r=%0d, want lat=%0d q=4 r=1", lat, quotient, remainder, W - 2);
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL start_busy_once: %0d extra busy/done cycles, want 0", extra);
        end
    endtask

    task automatic test_reset_mid;
        int   lat, bc, seen;
        exp_t e;
        launch(4'd12, 4'd5, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        void'(sb.pop_front());
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%b done=%b q=%0d r=%0d z=%b, want all zero",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL reset_discard: %0d busy/done cycles after release, want 0", seen);
        end
        launch(4'd12, 4'd5, 1'b0);
        wait_done(lat, bc);
        e = sb.pop_front();
        vectors++;
        if (lat != W || quotient !== 4'd2 || remainder !== 4'd2 || quotient !== e.q || remainder !== e.r) begin
            miscompares++;
            $display("FAIL reset_recover: lat=%0d q=%0d r=%0d, want lat=%0d q=2 r=2", lat, quotient, remainder, W);
        end
    endtask

    task automatic test_back_to_back;
        int   lat, bc;
        exp_t e;
        launch(4'd13, 4'd3, 1'b1);
        wait_done(lat, bc);
        e = sb.pop_front();
        vectors++;
        if (quotient !== e.q || remainder !== e.r) begin
            miscompares++;
            $display("FAIL b2b_first: q=%0d r=%0d, want q=%0d r=%0d", quotient, remainder, e.q, e.r);
        end
        dividend = 4'd11;
        divisor  = 4'd4;
        sb.push_back(model(4'd11, 4'd4));
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_no_idle: busy=%b done=%b, want busy=1 done=0", busy, done);
        end
        wait_done(lat, bc);
        e = sb.pop_front();
        vectors++;
        if (lat != W || quotient !== 4'd2 || remainder !== 4'd3 || quotient !== e.q || remainder !== e.r) begin
            miscompares++;
            $display("FAIL b2b_second: lat=%0d q=%0d r=%0d, want lat=%0d q=2 r=3", lat, quotient, remainder, W);
        end
        dividend = 4'd7;
        divisor  = 4'd0;
        sb.push_back(model(4'd7, 4'd0));
        @(negedge clk);
        start = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || quotient !== e.q || remainder !== e.r || div_by_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_zero: done=%b busy=%b q=%0d r=%0d z=%b, want done=1 busy=0 q=15 r=7 z=1",
                     done, busy, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drop: done=%b, want 0", done);
        end
    endtask

    task automatic test_sweep;
        int   lat, bc;
        exp_t e;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                launch(W'(a), W'(b), 1'b0);
                wait_done(lat, bc);
                e = sb.pop_front();
                vectors++;
                if (done !== 1'b1 || lat != ((b == 0) ? 0 : W) || quotient !== e.q
                    || remainder !== e.r || div_by_zero !== e.z) begin
                    miscompares++;
                    $display("FAIL sweep_%0d_%0d: lat=%0d q=%0d r=%0d z=%b, want q=%0d r=%0d z=%b",
                             a, b, lat, quotient, remainder, div_by_zero, e.q, e.r, e.z);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
